// File: rtl/dac_drive_ctrl.sv
// dac_drive_ctrl: slew-limited transducer drive level written to a 12-bit SPI DAC
// Ports:
//   clk, rst            system clock (rising edge), asynchronous active-high reset
//   cmd_valid           decoder valid; only its rising edge is acted on
//   on, off             enable drive / disable drive and ramp to 0 (off wins)
//   increase, decrease  move target by amount (both set: target unchanged)
//   amount              adjustment magnitude, zero-extended into level arithmetic
//   level               current drive level, the last value sent to the DAC
//   enabled             drive enabled flag
//   busy                frame in flight or level not yet at effective target
//   dac_cs_n            DAC chip select, active low
//   dac_sclk            DAC serial clock, idle low
//   dac_mosi            DAC data, MSB first, changes on SCLK falling edges
//   frame_done          one-cycle pulse in the cycle chip select returns high
module dac_drive_ctrl #(
    parameter int AMT_W     = 8,
    parameter int LEVEL_W   = 12,
    parameter int MAX_LEVEL = 4095,
    parameter int STEP_DIV  = 1000,
    parameter int SCLK_DIV  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic               on,
    input  logic               off,
    input  logic               increase,
    input  logic               decrease,
    input  logic [AMT_W-1:0]   amount,
    output logic [LEVEL_W-1:0] level,
    output logic               enabled,
    output logic               busy,
    output logic               dac_cs_n,
    output logic               dac_sclk,
    output logic               dac_mosi,
    output logic               frame_done
);
    localparam int TW = LEVEL_W + 1;
    localparam int FW = LEVEL_W + 4;
    localparam int CW = $clog2(STEP_DIV);
    localparam int DW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
    localparam int BW = $clog2(FW);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_END} state_t;

    state_t             state_q;
    logic [LEVEL_W-1:0] level_q, target_q, target_d, eff, lvl_nx;
    logic               enabled_q, enabled_d, cmd_valid_q, tick_pend_q, tick_pend_d;
    logic               accept, tick, go, div_end;
    logic [TW-1:0]      amt_x, sum, dif;
    logic [CW-1:0]      cnt_q;
    logic [DW-1:0]      div_q;
    logic [BW-1:0]      falls_q;
    logic [FW-1:0]      frame_w;
    logic [FW-2:0]      shift_q;
    logic               cs_n_q, sclk_q, mosi_q, done_q;

    always_comb begin
        // one extra bit so both saturation and borrow are visible
        amt_x = TW'(amount);
        sum = {1'b0, target_q} + amt_x;
        dif = {1'b0, target_q} - amt_x;
        accept = cmd_valid & ~cmd_valid_q;
        enabled_d = enabled_q;
        target_d = target_q;
        if (accept) begin
            if (off) begin
                enabled_d = 1'b0;
                target_d = '0;
            end else begin
                enabled_d = enabled_q | on;
                if (increase & ~decrease)
                    target_d = sum > TW'(MAX_LEVEL) ? LEVEL_W'(MAX_LEVEL) : sum[LEVEL_W-1:0];
                else if (decrease & ~increase)
                    target_d = dif[LEVEL_W] ? '0 : dif[LEVEL_W-1:0];
            end
        end
        eff = enabled_q ? target_q : '0;
        tick = cnt_q == CW'(STEP_DIV - 1);
        go = (tick | tick_pend_q) && state_q == S_IDLE && level_q != eff;
        lvl_nx = level_q < eff ? level_q + 1'b1 : level_q - 1'b1;
        frame_w = {4'b0011, lvl_nx};
        // a tick seen while idle is always consumed, stepped or not
        tick_pend_d = state_q != S_IDLE && (tick | tick_pend_q);
        div_end = div_q == DW'(SCLK_DIV - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            enabled_q <= 1'b0;
            target_q <= '0;
            tick_pend_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            cmd_valid_q <= cmd_valid;
            enabled_q <= enabled_d;
            target_q <= target_d;
            tick_pend_q <= tick_pend_d;
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

    // level and the frame outputs share one register stage so the new level
    // and the falling chip select appear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            level_q <= '0;
            shift_q <= '0;
            div_q <= '0;
            falls_q <= '0;
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (go) begin
                    level_q <= lvl_nx;
                    shift_q <= frame_w[FW-2:0];
                    mosi_q <= frame_w[FW-1];
                    cs_n_q <= 1'b0;
                    div_q <= '0;
                    state_q <= S_LOAD;
                end
                S_LOAD: if (div_end) begin
                    div_q <= '0;
                    sclk_q <= 1'b1;
                    falls_q <= '0;
                    state_q <= S_SHIFT;
                end else div_q <= div_q + 1'b1;
                S_SHIFT: if (div_end) begin
                    div_q <= '0;
                    sclk_q <= ~sclk_q;
                    if (sclk_q) begin
                        if (falls_q == BW'(FW - 1)) state_q <= S_END;
                        else begin
                            falls_q <= falls_q + 1'b1;
                            mosi_q <= shift_q[FW-2];
                            shift_q <= {shift_q[FW-3:0], 1'b0};
                        end
                    end
                end else div_q <= div_q + 1'b1;
                S_END: if (div_end) begin
                    cs_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    done_q <= 1'b1;
                    state_q <= S_IDLE;
                end else div_q <= div_q + 1'b1;
            endcase
        end
    end

    assign level = level_q;
    assign enabled = enabled_q;
    assign busy = state_q != S_IDLE || level_q != eff;
    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_mosi = mosi_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_dac_drive_ctrl.sv
// tb_dac_drive_ctrl: directed bench for dac_drive_ctrl (fast and deferred-tick configurations)
module tb_dac_drive_ctrl;
    logic clk = 1'b0, rst = 1'b0;
    logic cmd_valid = 1'b0, on = 1'b0, off = 1'b0, increase = 1'b0, decrease = 1'b0;
    logic [7:0] amount = 8'd0;
    logic [11:0] level;
    logic enabled, busy, dac_cs_n, dac_sclk, dac_mosi, frame_done;
    logic cv2 = 1'b0, on2 = 1'b0, off2 = 1'b0, inc2 = 1'b0, dec2 = 1'b0;
    logic [7:0] amt2 = 8'd0;
    logic [11:0] l2;
    logic en2, b2, cs2, sc2, mo2, fd2;

    int checks = 0, errors = 0;
    int run1 = 0, run2 = 0, fd_cnt = 0;
    logic [15:0] cap = 16'd0;

    typedef struct {
        logic on, off, inc, dec;
        logic [7:0] amt;
        logic exp_en;
        logic [11:0] exp_t;
    } vec_t;
    vec_t tbl[15];

    dac_drive_ctrl #(.AMT_W(8), .LEVEL_W(12), .MAX_LEVEL(4095), .STEP_DIV(8), .SCLK_DIV(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .on(on), .off(off),
        .increase(increase), .decrease(decrease), .amount(amount), .level(level),
        .enabled(enabled), .busy(busy), .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk),
        .dac_mosi(dac_mosi), .frame_done(frame_done));

    dac_drive_ctrl #(.AMT_W(8), .LEVEL_W(12), .MAX_LEVEL(4095), .STEP_DIV(2), .SCLK_DIV(4)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cv2), .on(on2), .off(off2),
        .increase(inc2), .decrease(dec2), .amount(amt2), .level(l2),
        .enabled(en2), .busy(b2), .dac_cs_n(cs2), .dac_sclk(sc2),
        .dac_mosi(mo2), .frame_done(fd2));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge dac_sclk) cap = {cap[14:0], dac_mosi};

    // chip select must stay low for exactly 33*SCLK_DIV cycles per frame
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (rst) run1 = 0;
        else if (!dac_cs_n) run1++;
        else if (run1 != 0) begin
            chk("cs_low_len", run1, 33);
            run1 = 0;
        end
        if (rst) run2 = 0;
        else if (!cs2) run2++;
        else if (run2 != 0) begin
            chk("u2_cs_low_len", run2, 132);
            run2 = 0;
        end
    end

    task automatic cmd(input logic o, input logic f, input logic i, input logic d, input logic [7:0] a);
        @(negedge clk);
        {on, off, increase, decrease, amount, cmd_valid} = {o, f, i, d, a, 1'b1};
        @(negedge clk);
        {on, off, increase, decrease, amount, cmd_valid} = '0;
    endtask

    task automatic cmd2(input logic o, input logic f, input logic i, input logic d, input logic [7:0] a);
        @(negedge clk);
        {on2, off2, inc2, dec2, amt2, cv2} = {o, f, i, d, a, 1'b1};
        @(negedge clk);
        {on2, off2, inc2, dec2, amt2, cv2} = '0;
    endtask

    task automatic wait_level(input int v);
        int n = 0;
        while (int'(level) != v && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_level", int'(level), v);
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 300);
        chk("wait_frame_done", int'(frame_done), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", int'(busy), 0);
    endtask

    initial begin
        int n, fdb;
        tbl = '{
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'd5,   1'b1, 12'd5},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'd200, 1'b1, 12'd205},
            '{1'b0, 1'b0, 1'b1, 1'b1, 8'd50,  1'b1, 12'd205},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd10,  1'b1, 12'd195},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1, 12'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'd255, 1'b1, 12'd255},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'd45,  1'b1, 12'd300},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1, 12'd45},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1, 12'd0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 8'd10,  1'b0, 12'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'd7,   1'b0, 12'd7},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 12'd7},
            '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 12'd0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1,   1'b0, 12'd0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 8'd9,   1'b0, 12'd0}
        };
        #2 rst = 1'b1;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_enabled", int'(enabled), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cs_n", int'(dac_cs_n), 1);
        chk("rst_sclk", int'(dac_sclk), 0);
        chk("rst_mosi", int'(dac_mosi), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // enable and ramp 0 -> 3 with one frame per step
        cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        chk("ramp_enabled", int'(enabled), 1);
        chk("ramp_target", int'(dut.target_q), 3);
        for (int k = 1; k <= 3; k++) begin
            wait_level(k);
            chk("ramp_cs_low_with_level", int'(dac_cs_n), 0);
            wait_fd();
            chk("ramp_dac_word", int'(cap), 16'h3000 + k);
            chk("ramp_level_at_done", int'(level), k);
            chk("ramp_busy_at_done", int'(busy), k < 3 ? 1 : 0);
        end

        // reset in the middle of a frame
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        wait_level(4);
        n = 0;
        while (!dac_sclk && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_frame_sclk_seen", int'(dac_sclk), 1);
        fdb = fd_cnt;
        #2 rst = 1'b1;
        #1;
        chk("abort_cs_n", int'(dac_cs_n), 1);
        chk("abort_sclk", int'(dac_sclk), 0);
        chk("abort_level", int'(level), 0);
        chk("abort_enabled", int'(enabled), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_frame_done", fd_cnt - fdb, 0);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_cs_n", int'(dac_cs_n), 1);
        chk("abort_target", int'(dut.target_q), 0);

        // command table
        for (int i = 0; i < 15; i++) begin
            cmd(tbl[i].on, tbl[i].off, tbl[i].inc, tbl[i].dec, tbl[i].amt);
            chk($sformatf("tbl%0d_enabled", i), int'(enabled), int'(tbl[i].exp_en));
            chk($sformatf("tbl%0d_target", i), int'(dut.target_q), int'(tbl[i].exp_t));
        end

        // saturation at the ceiling
        repeat (16) cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
        chk("sat_4080", int'(dut.target_q), 4080);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
        chk("sat_4090", int'(dut.target_q), 4090);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'd200);
        chk("sat_clamp", int'(dut.target_q), 4095);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
        chk("sat_hold", int'(dut.target_q), 4095);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'd255);
        chk("sat_dec", int'(dut.target_q), 3840);

        // held-high valid is accepted once
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        {increase, amount, cmd_valid} = {1'b1, 8'd5, 1'b1};
        repeat (50) @(negedge clk);
        chk("edge_once", int'(dut.target_q), 5);
        {increase, amount, cmd_valid} = '0;
        @(negedge clk);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        chk("edge_again", int'(dut.target_q), 10);

        // off beats increase and ramps 4 -> 0
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
        wait_idle();
        chk("off_start_level", int'(level), 4);
        fdb = fd_cnt;
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 8'd10);
        chk("off_enabled", int'(enabled), 0);
        chk("off_target", int'(dut.target_q), 0);
        wait_idle();
        chk("off_frames", fd_cnt - fdb, 4);
        chk("off_level", int'(level), 0);
        chk("off_target_after", int'(dut.target_q), 0);

        // conflict and deferred ticks (STEP_DIV=2, SCLK_DIV=4)
        cmd2(1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        chk("u2_enabled", int'(en2), 1);
        chk("u2_target", int'(dut2.target_q), 3);
        cmd2(1'b0, 1'b0, 1'b1, 1'b1, 8'd9);
        chk("u2_conflict", int'(dut2.target_q), 3);
        n = 0;
        while (cs2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("u2_first_launch", int'(cs2), 0);
        chk("u2_level1", int'(l2), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!fd2) chk("u2_level_frozen", int'(l2), 1);
        end while (!fd2 && n < 300);
        chk("u2_frame_done", int'(fd2), 1);
        chk("u2_level_at_done", int'(l2), 1);
        n = 0;
        while (cs2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("u2_pend_gap_ok", int'(n <= 2 && !cs2), 1);
        chk("u2_level2", int'(l2), 2);
        n = 0;
        while (b2 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("u2_idle", int'(b2), 0);
        chk("u2_level3", int'(l2), 3);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
